// File: rtl/l2cache_control_if.sv
// L2 controller bus bundle: upstream request/response, datapath status and strobes, pmem handshake, counters.
// Latency: none, the interface is wiring only.
// Backpressure: requests are held until mem_resp; pmem requests are held until pmem_resp.
interface l2cache_control_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_resp;
    logic                 hit_0;
    logic                 hit_1;
    logic                 lru;
    logic                 valid_lru;
    logic                 dirty_lru;
    logic                 pmem_resp;
    logic                 pmem_read;
    logic                 pmem_write;
    logic                 pmem_addr_sel;
    logic                 load_valid;
    logic                 load_tag;
    logic                 load_dirty;
    logic                 load_data;
    logic                 dirty_in;
    logic                 data_sel;
    logic                 way_sel;
    logic                 lru_load;
    logic                 lru_in;
    logic [CNT_WIDTH-1:0] hit_count;
    logic [CNT_WIDTH-1:0] miss_count;
    logic [CNT_WIDTH-1:0] wb_count;

    // Controller side: consumes requests and status, drives strobes and pmem requests.
    modport slave (
        input  mem_read, mem_write, hit_0, hit_1, lru, valid_lru, dirty_lru, pmem_resp,
        output mem_resp, pmem_read, pmem_write, pmem_addr_sel,
               load_valid, load_tag, load_dirty, load_data, dirty_in, data_sel, way_sel,
               lru_load, lru_in, hit_count, miss_count, wb_count
    );

    // Environment side: upstream arbiter, datapath and physical memory.
    modport master (
        output mem_read, mem_write, hit_0, hit_1, lru, valid_lru, dirty_lru, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, pmem_addr_sel,
               load_valid, load_tag, load_dirty, load_data, dirty_in, data_sel, way_sel,
               lru_load, lru_in, hit_count, miss_count, wb_count
    );
endinterface

// File: rtl/l2cache_control.sv
// Sequencing FSM for the two-way LRU L2 datapath with saturating hit/miss/writeback counters.
// Latency: hit responds 1 cycle after the request is seen in IDLE; misses add writeback/fill pmem time.
// Backpressure: upstream held until mem_resp; WRITEBACK/FILL hold pmem requests until pmem_resp.
module l2cache_control #(
    parameter int CNT_WIDTH = 32
) (
    input logic              clk,
    input logic              rst,
    l2cache_control_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    logic                 missed;
    logic [CNT_WIDTH-1:0] hit_cnt;
    logic [CNT_WIDTH-1:0] miss_cnt;
    logic [CNT_WIDTH-1:0] wb_cnt;

    logic req;
    logic is_write;
    logic hit;
    logic hit_way;

    assign req      = bus.mem_read | bus.mem_write;
    // A simultaneous read and write is serviced as a write.
    assign is_write = bus.mem_write;
    assign hit      = bus.hit_0 | bus.hit_1;
    // Way 0 wins when both ways report a match.
    assign hit_way  = ~bus.hit_0;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + CNT_ONE;
    endfunction

    // Combinational strobes and handshakes decoded from the current state and inputs.
    always_comb begin
        bus.mem_resp      = 1'b0;
        bus.pmem_read     = 1'b0;
        bus.pmem_write    = 1'b0;
        bus.pmem_addr_sel = 1'b0;
        bus.load_valid    = 1'b0;
        bus.load_tag      = 1'b0;
        bus.load_dirty    = 1'b0;
        bus.load_data     = 1'b0;
        bus.dirty_in      = 1'b0;
        bus.data_sel      = 1'b0;
        bus.way_sel       = 1'b0;
        bus.lru_load      = 1'b0;
        bus.lru_in        = 1'b0;
        case (state)
            CHECK: begin
                if (req && hit) begin
                    bus.way_sel  = hit_way;
                    bus.mem_resp = 1'b1;
                    bus.lru_load = 1'b1;
                    bus.lru_in   = ~hit_way;
                    if (is_write) begin
                        bus.load_data  = 1'b1;
                        bus.load_dirty = 1'b1;
                        bus.dirty_in   = 1'b1;
                    end
                end
            end
            WRITEBACK: begin
                bus.pmem_write    = 1'b1;
                bus.pmem_addr_sel = 1'b1;
            end
            FILL: begin
                bus.pmem_read = 1'b1;
                bus.way_sel   = bus.lru;
                if (bus.pmem_resp) begin
                    bus.load_data  = 1'b1;
                    bus.data_sel   = 1'b1;
                    bus.load_tag   = 1'b1;
                    bus.load_valid = 1'b1;
                    bus.load_dirty = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // State transitions, the per-request missed flag and the saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            missed   <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    missed <= 1'b0;
                    if (req) state <= CHECK;
                end
                CHECK: begin
                    if (!req) begin
                        state  <= IDLE;
                        missed <= 1'b0;
                    end else if (hit) begin
                        state  <= IDLE;
                        missed <= 1'b0;
                        if (!missed) hit_cnt <= sat_inc(hit_cnt);
                    end else begin
                        missed <= 1'b1;
                        if (!missed) miss_cnt <= sat_inc(miss_cnt);
                        state <= (bus.valid_lru && bus.dirty_lru) ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (bus.pmem_resp) begin
                        wb_cnt <= sat_inc(wb_cnt);
                        state  <= FILL;
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) state <= CHECK;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;
    assign bus.wb_count   = wb_cnt;
endmodule

// File: tb/tb_l2cache_control.sv
// Directed bench for l2cache_control with a response scoreboard.
// Latency: checks exact hit/miss response cycles.
// Backpressure: bench models upstream holding requests and pmem replying after fixed delays.
module tb_l2cache_control;
    localparam int CW = 2;

    typedef struct packed {
        logic way_sel;
        logic load_data;
        logic data_sel;
        logic load_dirty;
        logic dirty_in;
        logic lru_in;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    resp_t exp_q[$];

    l2cache_control_if #(.CNT_WIDTH(CW)) bus ();

    l2cache_control #(.CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.hit_0     = 1'b0;
        bus.hit_1     = 1'b0;
        bus.lru       = 1'b0;
        bus.valid_lru = 1'b0;
        bus.dirty_lru = 1'b0;
        bus.pmem_resp = 1'b0;
    endtask

    // Pops the oldest expected response and compares it to the current strobes.
    task automatic check_resp(input string tag);
        resp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_resp"}, 32'(bus.mem_resp), 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_lru_load"},   32'(bus.lru_load),   32'd1);
            chk({tag, "_way_sel"},    32'(bus.way_sel),    32'(e.way_sel));
            chk({tag, "_load_data"},  32'(bus.load_data),  32'(e.load_data));
            chk({tag, "_data_sel"},   32'(bus.data_sel),   32'(e.data_sel));
            chk({tag, "_load_dirty"}, 32'(bus.load_dirty), 32'(e.load_dirty));
            chk({tag, "_dirty_in"},   32'(bus.dirty_in),   32'(e.dirty_in));
            chk({tag, "_lru_in"},     32'(bus.lru_in),     32'(e.lru_in));
        end
    endtask

    // Waits a bounded number of cycles for mem_resp, checking pmem exclusivity meanwhile.
    task automatic await_resp(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            chk({tag, "_pmem_excl"}, 32'(bus.pmem_read & bus.pmem_write), 32'd0);
            if (bus.mem_resp) begin
                seen = 1'b1;
                check_resp(tag);
            end else begin
                next_cycle();
                #2;
            end
        end
        if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        chk("rst_state",      32'(dut.state),      32'd0);
        chk("rst_mem_resp",   32'(bus.mem_resp),   32'd0);
        chk("rst_pmem_read",  32'(bus.pmem_read),  32'd0);
        chk("rst_pmem_write", 32'(bus.pmem_write), 32'd0);
        chk("rst_counters",   32'(bus.hit_count | bus.miss_count | bus.wb_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();

        // Read hit on way 1.
        do_reset();
        bus.mem_read = 1'b1;
        bus.hit_1    = 1'b1;
        exp_q.push_back('{way_sel: 1'b1, load_data: 1'b0, data_sel: 1'b0,
                          load_dirty: 1'b0, dirty_in: 1'b0, lru_in: 1'b0});
        #2 chk("rdhit_c0_resp", 32'(bus.mem_resp), 32'd0);
        next_cycle();
        #2 chk("rdhit_c1_resp", 32'(bus.mem_resp), 32'd1);
        check_resp("rdhit");
        next_cycle();
        #2 chk("rdhit_idle_gap", 32'(bus.mem_resp), 32'd0);
        chk("rdhit_hit_count", 32'(bus.hit_count), 32'd1);
        clear_inputs();

        // Write hit with both ways matching: way 0 wins.
        do_reset();
        bus.mem_write = 1'b1;
        bus.hit_0     = 1'b1;
        bus.hit_1     = 1'b1;
        exp_q.push_back('{way_sel: 1'b0, load_data: 1'b1, data_sel: 1'b0,
                          load_dirty: 1'b1, dirty_in: 1'b1, lru_in: 1'b1});
        next_cycle();
        #2 chk("wrhit_c1_resp", 32'(bus.mem_resp), 32'd1);
        check_resp("wrhit");
        next_cycle();
        clear_inputs();
        #2 chk("wrhit_hit_count", 32'(bus.hit_count), 32'd1);

        // Clean miss into way 1, pmem replies on the 5th FILL cycle.
        do_reset();
        bus.mem_read = 1'b1;
        bus.lru      = 1'b1;
        exp_q.push_back('{way_sel: 1'b1, load_data: 1'b0, data_sel: 1'b0,
                          load_dirty: 1'b0, dirty_in: 1'b0, lru_in: 1'b0});
        next_cycle();
        #2 chk("clean_check_pmem", 32'(bus.pmem_read | bus.pmem_write), 32'd0);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            if (i == 4) bus.pmem_resp = 1'b1;
            #2;
            chk("clean_pmem_read", 32'(bus.pmem_read), 32'd1);
            chk("clean_addr_sel",  32'(bus.pmem_addr_sel), 32'd0);
            chk("clean_load_data", 32'(bus.load_data), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("clean_fill_strobes",
            32'({bus.load_tag, bus.load_valid, bus.data_sel, bus.way_sel, bus.load_dirty, bus.dirty_in}),
            32'b111110);
        next_cycle();
        bus.pmem_resp = 1'b0;
        bus.hit_1     = 1'b1;
        #2 chk("clean_resp_now", 32'(bus.mem_resp), 32'd1);
        check_resp("clean");
        next_cycle();
        clear_inputs();
        #2 chk("clean_miss_count", 32'(bus.miss_count), 32'd1);
        chk("clean_hit_count", 32'(bus.hit_count), 32'd0);

        // Dirty miss, read+write held together (serviced as a write), victim way 0.
        do_reset();
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b1;
        bus.valid_lru = 1'b1;
        bus.dirty_lru = 1'b1;
        exp_q.push_back('{way_sel: 1'b0, load_data: 1'b1, data_sel: 1'b0,
                          load_dirty: 1'b1, dirty_in: 1'b1, lru_in: 1'b1});
        next_cycle();
        #2 chk("dirty_check_pmem", 32'(bus.pmem_read | bus.pmem_write), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            if (i == 2) bus.pmem_resp = 1'b1;
            #2;
            chk("dirty_wb_write", 32'(bus.pmem_write), 32'd1);
            chk("dirty_wb_read",  32'(bus.pmem_read), 32'd0);
            chk("dirty_wb_addr",  32'(bus.pmem_addr_sel), 32'd1);
        end
        next_cycle();
        bus.pmem_resp = 1'b0;
        bus.dirty_lru = 1'b0;
        #2 chk("dirty_wb_count", 32'(bus.wb_count), 32'd1);
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin
                next_cycle();
                bus.pmem_resp = 1'b1;
            end
            #2;
            chk("dirty_fill_read",  32'(bus.pmem_read), 32'd1);
            chk("dirty_fill_write", 32'(bus.pmem_write), 32'd0);
            chk("dirty_fill_addr",  32'(bus.pmem_addr_sel), 32'd0);
        end
        next_cycle();
        bus.pmem_resp = 1'b0;
        bus.hit_0     = 1'b1;
        #2 await_resp(3, "dirty");
        chk("dirty_miss_count", 32'(bus.miss_count), 32'd1);
        chk("dirty_hit_count",  32'(bus.hit_count), 32'd0);
        next_cycle();
        clear_inputs();

        // Request withdrawn while in CHECK.
        do_reset();
        bus.mem_read = 1'b1;
        next_cycle();
        bus.mem_read = 1'b0;
        #2 chk("wd_strobes", 32'({bus.mem_resp, bus.lru_load, bus.pmem_read, bus.pmem_write}), 32'd0);
        next_cycle();
        #2 chk("wd_state", 32'(dut.state), 32'd0);
        chk("wd_miss_count", 32'(bus.miss_count), 32'd0);

        // Reset asserted mid-FILL.
        do_reset();
        bus.mem_read = 1'b1;
        next_cycle();
        next_cycle();
        #2 chk("rstfill_pmem_read", 32'(bus.pmem_read), 32'd1);
        chk("rstfill_miss_before", 32'(bus.miss_count), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstfill_pmem_drop", 32'(bus.pmem_read), 32'd0);
        chk("rstfill_state",     32'(dut.state), 32'd0);
        chk("rstfill_counters",  32'(bus.hit_count | bus.miss_count | bus.wb_count), 32'd0);
        clear_inputs();

        // Hit counter saturation at CNT_WIDTH=2.
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            bus.mem_read = 1'b1;
            bus.hit_0    = 1'b1;
            exp_q.push_back('{way_sel: 1'b0, load_data: 1'b0, data_sel: 1'b0,
                              load_dirty: 1'b0, dirty_in: 1'b0, lru_in: 1'b1});
            next_cycle();
            #2 chk("sat_resp", 32'(bus.mem_resp), 32'd1);
            check_resp("sat");
            next_cycle();
            bus.mem_read = 1'b0;
            bus.hit_0    = 1'b0;
            #2 chk("sat_hit_count", 32'(bus.hit_count), (k < 3) ? 32'(k) : 32'd3);
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
